pwm_timer: RTL

Parametrised multi-channel PWM timer: one shared counter with prescaler, up, down and center-aligned count modes, and NCH compare channels with per-channel polarity. All configuration is double-buffered (shadow then active) and takes effect only at an update event (UEV). It sits between the register interface, which drives the `*_in`/`load` inputs, and the pad drivers.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_prescaler.sv | 27 ++
 rtl/pwm_timer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode type, parameter defaults and restart helper for pwm_timer
package pwm_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NCH   = 4;
  localparam int DEF_PSC_W = 16;
  // Helper width; WIDTH must not exceed this.
  localparam int MAX_W     = 32;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_CENTER = 2'd2
  } mode_e;

  // Raw encoding 3 is reserved and runs as UP.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_DOWN;
      2'd2:    return MODE_CENTER;
      default: return MODE_UP;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] restart_cnt(input mode_e mode, input logic [MAX_W-1:0] arr);
    return (mode == MODE_DOWN) ? arr : '0;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - divide-by-(psc_a+1) tick generator, cleared on every update event
module pwm_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PSC_W-1:0] psc_a,
  input  logic             clr,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt;

  assign tick = en && (psc_cnt == psc_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt <= '0;
    end else if (clr) begin
      psc_cnt <= '0;
    end else if (en) begin
      psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_timer.sv
// rtl/pwm_timer.sv - shared-counter multi-channel PWM timer with double-buffered configuration
module pwm_timer import pwm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int PSC_W = DEF_PSC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic               ug,
  input  logic [1:0]         mode_in,
  input  logic [WIDTH-1:0]   arr_in,
  input  logic [PSC_W-1:0]   psc_in,
  input  logic [NCH*WIDTH-1:0] ccr_in,
  input  logic [NCH-1:0]     pol_in,
  output logic [NCH-1:0]     wave,
  output logic [WIDTH-1:0]   cnt,
  output logic               dir,
  output logic               upd
);

  logic [1:0]           mode_s, mode_a;
  logic [WIDTH-1:0]     arr_s, arr_a;
  logic [PSC_W-1:0]     psc_s, psc_a;
  logic [NCH*WIDTH-1:0] ccr_s, ccr_a;
  logic [NCH-1:0]       pol_s, pol_a;

  mode_e            mode_cur, mode_nxt;
  logic             tick, uev, wrap;
  logic [WIDTH-1:0] cnt_step;
  logic             dir_step;

  assign mode_cur = decode_mode(mode_a);
  assign mode_nxt = decode_mode(mode_s);

  pwm_prescaler #(.PSC_W(PSC_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .psc_a (psc_a),
    .clr   (uev),
    .tick  (tick)
  );

  // Next counter position for a tick, and whether this tick ends the period.
  always_comb begin
    wrap     = 1'b0;
    cnt_step = cnt;
    dir_step = dir;
    case (mode_cur)
      MODE_DOWN: begin
        if (cnt == '0) wrap = 1'b1;
        else           cnt_step = cnt - WIDTH'(1);
      end
      MODE_CENTER: begin
        if (!dir) begin
          if (cnt == arr_a) begin
            if (arr_a <= WIDTH'(1)) begin
              wrap = 1'b1;
            end else begin
              dir_step = 1'b1;
              cnt_step = arr_a - WIDTH'(1);
            end
          end else begin
            cnt_step = cnt + WIDTH'(1);
          end
        end else begin
          if (cnt == WIDTH'(1)) wrap = 1'b1;
          else                  cnt_step = cnt - WIDTH'(1);
        end
      end
      default: begin
        if (cnt == arr_a) wrap = 1'b1;
        else              cnt_step = cnt + WIDTH'(1);
      end
    endcase
  end

  assign uev = ug || (tick && wrap);

  // Active registers copy the pre-edge shadow, so a same-edge load waits one period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_s <= '0;
      arr_s  <= '0;
      psc_s  <= '0;
      ccr_s  <= '0;
      pol_s  <= '0;
      mode_a <= '0;
      arr_a  <= '0;
      psc_a  <= '0;
      ccr_a  <= '0;
      pol_a  <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      upd    <= 1'b0;
    end else begin
      if (load) begin
        mode_s <= mode_in;
        arr_s  <= arr_in;
        psc_s  <= psc_in;
        ccr_s  <= ccr_in;
        pol_s  <= pol_in;
      end
      if (uev) begin
        mode_a <= mode_s;
        arr_a  <= arr_s;
        psc_a  <= psc_s;
        ccr_a  <= ccr_s;
        pol_a  <= pol_s;
        cnt    <= WIDTH'(restart_cnt(mode_nxt, MAX_W'(arr_s)));
        dir    <= (mode_nxt == MODE_DOWN);
      end else if (tick) begin
        cnt    <= cnt_step;
        dir    <= dir_step;
      end
      upd <= uev;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wave[i] = (cnt < ccr_a[i*WIDTH +: WIDTH]) ^ pol_a[i];
  end

endmodule
